// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage handshake and HI/LO bus between the pipeline and the mul/div unit
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic [1:0]      hilo_we;
    logic [XLEN-1:0] hilo_wdata;
    logic            exe_stall;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush, hilo_we, hilo_wdata,
        input  exe_stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hilo_we, hilo_wdata,
        output exe_stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative shift-add multiplier / restoring divider owning the HI/LO registers
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    ex_muldiv_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              is_div;
    logic              neg_lo;
    logic              neg_hi;
    logic              dz;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic              a_s;
    logic              b_s;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_nx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;
    logic              last_step;

    // Operand magnitudes and one iteration step; acc holds {partial, multiplier} or {remainder, dividend}
    always_comb begin
        a_s       = !bus.op[0] && bus.src_a[XLEN-1];
        b_s       = !bus.op[0] && bus.src_b[XLEN-1];
        a_mag     = a_s ? -bus.src_a : bus.src_a;
        b_mag     = b_s ? -bus.src_b : bus.src_b;
        add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted   = acc[2*XLEN-1:XLEN-1];
        diff      = shifted - {1'b0, opnd};
        acc_nx    = !is_div ? {add_sum, acc[XLEN-1:1]} :
                    diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                                 {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod      = neg_lo ? -acc_nx : acc_nx;
        res_lo    = !is_div ? prod[XLEN-1:0] :
                    dz ? '1 :
                    neg_lo ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        res_hi    = !is_div ? prod[2*XLEN-1:XLEN] :
                    neg_hi ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        last_step = state == CALC && !bus.flush && count == LAST;
    end

    // Control FSM: latch magnitudes and result signs at start, iterate in CALC, abort on flush
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.flush) begin
                    state  <= CALC;
                    count  <= '0;
                    acc    <= {{XLEN{1'b0}}, bus.op[1] ? a_mag : b_mag};
                    opnd   <= bus.op[1] ? b_mag : a_mag;
                    is_div <= bus.op[1];
                    neg_lo <= a_s ^ b_s;
                    neg_hi <= bus.op[1] ? a_s : a_s ^ b_s;
                    dz     <= bus.op[1] && bus.src_b == '0;
                end
                CALC: if (bus.flush) begin
                    state <= IDLE;
                end else begin
                    acc   <= acc_nx;
                    count <= count + 1'b1;
                    if (count == LAST) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // HI/LO: final result on the last CALC step, MTHI/MTLO writes whenever not calculating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (last_step) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (state != CALC) begin
            if (bus.hilo_we[1]) hi_q <= bus.hilo_wdata;
            if (bus.hilo_we[0]) lo_q <= bus.hilo_wdata;
        end
    end

    assign bus.exe_stall   = (state == IDLE && bus.start && !bus.flush) || (state == CALC && !bus.flush);
    assign bus.done        = state == DONE;
    assign bus.div_by_zero = state == DONE && dz;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage; consumes operands from the ID/EX pipeline register and owns the architectural HI/LO registers.
- Drives back the `exe_stall` that freezes ID/EX while a MULT/MULTU/DIV/DIVU is in flight.
- Handles MTHI/MTLO writes.
- Results are read by MFHI/MFLO through the `hi`/`lo` outputs.

Parameters:
- XLEN, 32, operand width; HI/LO are XLEN each.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  EX holds a mul/div instruction; held high while stalled
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  XLEN  rs operand (multiplicand/dividend)
- src_b  input  XLEN  rt operand (multiplier/divisor)
- flush  input  1  abort in-flight operation (branch/exception squash)
- hilo_we  input  2  bit1 write HI, bit0 write LO (MTHI/MTLO)
- hilo_wdata  input  XLEN  data for hilo_we writes
- exe_stall  output  1  freeze ID/EX and earlier stages
- done  output  1  one-cycle pulse, HI/LO just updated by mul/div
- div_by_zero  output  1  pulses with done when a DIV/DIVU divisor is 0
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is asynchronous, active-low.
- Reset values: state=IDLE, count=0, hi=0, lo=0, done=0, div_by_zero=0, exe_stall=0. Reset asserted mid-operation aborts it and discards partial results.
- FSM states: IDLE, CALC, DONE.
  - IDLE: if start and !flush, latch op and operand magnitudes (two's-complement abs for MULT/DIV; raw for unsigned); record result signs; count=0; go to CALC.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; count increments.
    - When count==ITER-1, write final HI/LO at that edge and go to DONE.
    - flush in CALC: go to IDLE, HI/LO unchanged, no done.
  - DONE: done=1 for one cycle; go to IDLE. start is ignored in DONE, because it is the same instruction still in EX.
- exe_stall: combinational. Equals (state==IDLE & start & !flush) | (state==CALC & !flush). It is 0 in DONE, so ID/EX advances at the end of the DONE cycle.
- Latency: start sampled at edge E0; CALC occupies E1..E32; done is high in the cycle after E32. exe_stall is high for 33 consecutive cycles.
- Mul result: 64-bit product; HI=upper XLEN bits, LO=lower XLEN bits. Signed result is negated when operand signs differ.
- Div results:
  - LO=quotient, HI=remainder.
  - Quotient is negated when signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0.
- Divisor 0 (checked at start): full latency still elapses; LO=all ones, HI=src_a as latched; div_by_zero=1 with done.
- hilo_we: applied at the clock edge in IDLE or DONE, independent of start; ignored in CALC.
  - hilo_we with start in the same IDLE cycle: the write lands first; the mul/div result later overwrites both registers.
- hi/lo: registered outputs, stable during CALC. No forwarding of in-flight results.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> after 33 stall cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1, done pulses once; a second op is not started while start stays high in DONE.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100, div_by_zero=1 coincident with done, 33-cycle stall.
- hilo_we=2'b11 with hilo_wdata=0x12345678 in IDLE -> HI=LO=0x12345678 next cycle. Then flush at CALC count 10 -> exe_stall drops, HI/LO remain 0x12345678, no done.
- resetn low at CALC count 20 -> immediate IDLE, hi=lo=0, exe_stall=0. After release, MULTU 6×7 -> LO=42, HI=0.
